phase_capture_bank: RTL

PHASE_CAPTURE_BANK -- requirements
Module: phase_capture_bank

---
 rtl/phase_capture_pkg.sv | 12 +
 rtl/phase_counter.sv | 26 ++
 rtl/phase_capture_bank.sv | 69 ++++++
 3 files changed

// File: rtl/phase_capture_pkg.sv
// Shared defaults for the phase capture bank: widths, channel count and the
// default arming mask (phases 4 and 6).
package phase_capture_pkg;

   localparam int PCB_DATA_W   = 4;
   localparam int PCB_CHANNELS = 2;
   localparam int PCB_PHASE_W  = 3;
   localparam int PCB_NPH      = 1 << PCB_PHASE_W;

   localparam logic [PCB_NPH-1:0] PCB_PHASE_MASK = 8'b0101_0000;

endpackage

// File: rtl/phase_counter.sv
// Free-running phase counter: +1 per enabled cycle, natural wrap at 2**PHASE_W.
// Zero latency on phase; no backpressure, enable low simply freezes the count.
module phase_counter #(
   parameter int PHASE_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   output logic [PHASE_W-1:0] phase
);

   logic [PHASE_W-1:0] phase_q, phase_d;

   always_comb begin
      phase_d = phase_q;
      if (enable) phase_d = phase_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) phase_q <= '0;
      else        phase_q <= phase_d;
   end

   assign phase = phase_q;

endmodule

// File: rtl/phase_capture_bank.sv
// Per-channel capture registers loaded on armed phases; 1-cycle capture latency.
// Valid/ready output: new captures never stall, unconsumed data gets overwritten and flags sticky overrun.
module phase_capture_bank
   import phase_capture_pkg::*;
#(
   parameter int DATA_W   = PCB_DATA_W,
   parameter int CHANNELS = PCB_CHANNELS,
   parameter int PHASE_W  = PCB_PHASE_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic [(1<<PHASE_W)-1:0]      phase_mask,
   input  logic [CHANNELS-1:0]          ch_en,
   input  logic [CHANNELS*DATA_W-1:0]   data_in,
   output logic [CHANNELS*DATA_W-1:0]   data_out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         overrun,
   input  logic                         overrun_clr,
   output logic [PHASE_W-1:0]           phase_out
);

   logic [CHANNELS*DATA_W-1:0] data_q, data_d;
   logic                       valid_q, valid_d;
   logic                       overrun_q, overrun_d;
   logic                       cap_evt;

   phase_counter #(.PHASE_W(PHASE_W)) u_phase_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .phase  (phase_out)
   );

   // An armed phase with every channel disabled is not a capture at all.
   assign cap_evt = enable & phase_mask[phase_out] & (|ch_en);

   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      for (int k = 0; k < CHANNELS; k++) begin
         if (cap_evt && ch_en[k]) data_d[k*DATA_W +: DATA_W] = data_in[k*DATA_W +: DATA_W];
      end
      if (cap_evt)        valid_d = 1'b1;
      else if (out_ready) valid_d = 1'b0;
      // Set beats clear when both land in the same cycle.
      if (cap_evt && valid_q && !out_ready) overrun_d = 1'b1;
      else if (overrun_clr)                 overrun_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign data_out  = data_q;
   assign out_valid = valid_q;
   assign overrun   = overrun_q;

endmodule
